// File: rtl/qsfp_sb_scan.sv
// Purpose : scans the QSFP cages' TCA6406 sideband expanders through PCA9545 I2C switches.
//           It drives LPMODE/RESETL to each cage and latches MODPRSL/INTL back from it.
// Latency : one I2C command per state; the next command goes out the cycle after the
//           response (or the timeout) of the previous one.
// Backpressure: each command is held until cmd_valid&cmd_ready. Only one command is
//           ever outstanding.
// Ports   : clk/reset (sync, active-high); enable gates scanning; lpmode/resetl are the
//           per-cage requests; cmd_* and rsp_* form the I2C master handshake;
//           modprsl/intl/err/chg are per-cage status; chg_clr is write-1-to-clear;
//           irq is high while chg is non-zero; scan_done pulses at the end of a pass.
module qsfp_sb_scan #(
  parameter int         NUM_QSFP      = 4,
  parameter int         QSFP_PER_MUX  = 2,
  parameter logic [7:0] MUX_ADDR_BASE = 8'hE0,
  parameter logic [7:0] EXP_ADDR      = 8'h40,
  parameter int         POLL_CYCLES   = 1000000,
  parameter int         RSP_TIMEOUT   = 65535
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_QSFP-1:0] lpmode,
  input  logic [NUM_QSFP-1:0] resetl,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [1:0]          cmd_op,
  output logic [7:0]          cmd_dev,
  output logic [7:0]          cmd_reg,
  output logic [7:0]          cmd_wdata,
  input  logic                rsp_valid,
  input  logic [7:0]          rsp_rdata,
  input  logic                rsp_nack,
  output logic [NUM_QSFP-1:0] modprsl,
  output logic [NUM_QSFP-1:0] intl,
  output logic [NUM_QSFP-1:0] err,
  output logic [NUM_QSFP-1:0] chg,
  input  logic [NUM_QSFP-1:0] chg_clr,
  output logic                irq,
  output logic                scan_done
);

  localparam int IW = (NUM_QSFP > 1) ? $clog2(NUM_QSFP) : 1;
  localparam int TW = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, MUX_SEL, CFG, OUT, RD, MUX_DESEL, NEXT, WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pend_q;        // command accepted, response still owed
  logic [TW-1:0]   tmo_q;         // cycles since the accepting handshake
  logic [PW-1:0]   poll_q;
  logic            hold_q;        // command presented but not yet accepted
  logic [7:0]      hold_wdata_q;
  logic [7:0]      live_wdata;
  logic [7:0]      mux_dev;
  logic [7:0]      mux_sel;
  logic            cmd_fire;
  logic            rsp_hit, tmo_hit, rsp_done, rsp_bad, rsp_good;
  logic            last_cage;
  logic [NUM_QSFP-1:0] chg_set;
  logic            unused_rdata;

  assign unused_rdata = ^{rsp_rdata[7:3], rsp_rdata[0]};

  assign mux_dev = MUX_ADDR_BASE + 8'(4 * (int'(idx_q) / QSFP_PER_MUX));
  assign mux_sel = 8'(32'd1 << (2 * (int'(idx_q) % QSFP_PER_MUX)));

  assign cmd_valid = (state_q inside {MUX_SEL, CFG, OUT, RD, MUX_DESEL}) && !pend_q;
  assign cmd_fire  = cmd_valid && cmd_ready;

  // A response is only meaningful while one is owed; a response in the very
  // cycle the count reaches RSP_TIMEOUT still wins over the timeout.
  assign rsp_hit   = pend_q && rsp_valid;
  assign tmo_hit   = pend_q && !rsp_valid && (tmo_q == TW'(RSP_TIMEOUT));
  assign rsp_done  = rsp_hit || tmo_hit;
  assign rsp_bad   = (rsp_hit && rsp_nack) || tmo_hit;
  assign rsp_good  = rsp_hit && !rsp_nack;
  assign last_cage = (idx_q == IW'(NUM_QSFP - 1));

  assign chg_set = (rsp_good && state_q == RD && (rsp_rdata[2] != modprsl[idx_q]))
                   ? (NUM_QSFP'(1) << idx_q) : '0;
  assign irq     = |chg;

  // Once presented, wdata is frozen so LPMODE/RESETL changes cannot alter a
  // command the master may already be serialising.
  assign cmd_wdata = hold_q ? hold_wdata_q : live_wdata;

  always_comb begin
    cmd_op     = 2'b00;
    cmd_dev    = 8'h00;
    cmd_reg    = 8'h00;
    live_wdata = 8'h00;
    case (state_q)
      MUX_SEL: begin
        cmd_dev    = mux_dev;
        live_wdata = mux_sel;
      end
      CFG: begin
        cmd_op     = 2'b01;
        cmd_dev    = EXP_ADDR;
        cmd_reg    = 8'h03;
        live_wdata = 8'hE6;
      end
      OUT: begin
        cmd_op     = 2'b01;
        cmd_dev    = EXP_ADDR;
        cmd_reg    = 8'h01;
        live_wdata = {3'b000, resetl[idx_q], 1'b0, 2'b00, lpmode[idx_q]};
      end
      RD: begin
        cmd_op     = 2'b10;
        cmd_dev    = EXP_ADDR;
        cmd_reg    = 8'h00;
      end
      MUX_DESEL: begin
        cmd_dev    = mux_dev;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    scan_done = 1'b0;
    case (state_q)
      IDLE: if (enable) begin
        state_d = MUX_SEL;
        idx_d   = '0;
      end
      // A failed select means no channel was opened, so skip the deselect.
      MUX_SEL:   if (rsp_done) state_d = rsp_bad ? NEXT : CFG;
      CFG:       if (rsp_done) state_d = rsp_bad ? MUX_DESEL : OUT;
      OUT:       if (rsp_done) state_d = rsp_bad ? MUX_DESEL : RD;
      RD:        if (rsp_done) state_d = MUX_DESEL;
      MUX_DESEL: if (rsp_done) state_d = NEXT;
      // Enable is honoured here, after the deselect, so no channel stays open.
      NEXT: begin
        if (last_cage) begin
          scan_done = 1'b1;
          idx_d     = '0;
          state_d   = WAIT;
        end else if (!enable) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = MUX_SEL;
        end
      end
      WAIT: if (poll_q == PW'(POLL_CYCLES - 1)) begin
        idx_d   = '0;
        state_d = enable ? MUX_SEL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      tmo_q        <= '0;
      poll_q       <= '0;
      hold_q       <= 1'b0;
      hold_wdata_q <= 8'h00;
      modprsl      <= '1;
      intl         <= '1;
      err          <= '0;
      chg          <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;

      if (cmd_fire) begin
        pend_q <= 1'b1;
        tmo_q  <= TW'(1);
      end else if (rsp_done) begin
        pend_q <= 1'b0;
        tmo_q  <= '0;
      end else if (pend_q) begin
        tmo_q  <= tmo_q + TW'(1);
      end

      poll_q <= (state_q == WAIT) ? poll_q + PW'(1) : '0;

      if (cmd_valid && !cmd_ready) begin
        hold_q       <= 1'b1;
        hold_wdata_q <= cmd_wdata;
      end else begin
        hold_q       <= 1'b0;
      end

      if (rsp_bad) begin
        err[idx_q] <= 1'b1;
      end else if (rsp_good && state_q == RD) begin
        err[idx_q]     <= 1'b0;
        modprsl[idx_q] <= rsp_rdata[2];
        intl[idx_q]    <= rsp_rdata[1];
      end

      // A new change in the same cycle as its clear must survive.
      chg <= (chg & ~chg_clr) | chg_set;
    end
  end

endmodule

// File: doc/qsfp_sb_scan.md
QSFP_SB_SCAN -- requirements
Module: qsfp_sb_scan

Interface
REQ-001 SHALL provide parameter NUM_QSFP, default 4, meaning number of cages scanned (legal 1..8).
REQ-002 SHALL provide parameter QSFP_PER_MUX, default 2, meaning cages per PCA9545 switch.
REQ-003 SHALL provide parameter MUX_ADDR_BASE, default 8'hE0, meaning 8-bit write address of the first switch; switch k is at MUX_ADDR_BASE+4*k.
REQ-004 SHALL provide parameter EXP_ADDR, default 8'h40, meaning 8-bit write address of every cage's TCA6406 sideband expander.
REQ-005 SHALL provide parameter POLL_CYCLES, default 1000000, meaning idle cycles between scan passes.
REQ-006 SHALL provide parameter RSP_TIMEOUT, default 65535, meaning maximum cycles to wait for an I2C response.
REQ-007 SHALL provide port clk, input, 1, the only clock.
REQ-008 SHALL provide port reset, input, 1; reset is synchronous and active-high.
REQ-009 SHALL provide port enable, input, 1, meaning scanning is allowed.
REQ-010 SHALL provide port lpmode, input, NUM_QSFP, meaning requested LPMODE per cage.
REQ-011 SHALL provide port resetl, input, NUM_QSFP, meaning requested RESETL per cage.
REQ-012 SHALL provide cmd_valid output 1, cmd_ready input 1, cmd_op output 2 (00 write-byte no register, 01 write-register, 10 read-register), cmd_dev output 8, cmd_reg output 8, and cmd_wdata output 8.
REQ-013 SHALL provide rsp_valid input 1, rsp_rdata input 8, and rsp_nack input 1.
REQ-014 SHALL provide outputs modprsl, intl, err, and chg, each NUM_QSFP wide, carrying latched MODPRSL, latched INTL, last-pass error, and sticky MODPRSL-change status.
REQ-015 SHALL provide input chg_clr, NUM_QSFP wide, as a write-1-to-clear for chg.
REQ-016 SHALL provide output irq, 1, level-high while chg is non-zero.
REQ-017 SHALL provide output scan_done, 1, a one-cycle pulse at the end of each pass.

Function
REQ-018 SHALL implement states IDLE, MUX_SEL, CFG, OUT, RD, MUX_DESEL, NEXT, and WAIT.
REQ-019 SHALL move from IDLE to MUX_SEL with cage index i=0 when enable=1.
REQ-020 SHALL issue, in MUX_SEL, op 00 to dev MUX_ADDR_BASE+4*(i/QSFP_PER_MUX) with wdata 1<<(2*(i%QSFP_PER_MUX)).
REQ-021 SHALL issue, in CFG, op 01 to dev EXP_ADDR with reg 8'h03 and wdata 8'hE6.
REQ-022 SHALL issue, in OUT, op 01 to dev EXP_ADDR with reg 8'h01 and wdata {3'b000, resetl[i], 1'b0, 2'b00, lpmode[i]}, with lpmode and resetl sampled in the cycle cmd_valid first asserts.
REQ-023 SHALL issue, in RD, op 10 to dev EXP_ADDR with reg 8'h00; on a good response it SHALL latch modprsl[i]=rdata[2] and intl[i]=rdata[1].
REQ-024 SHALL issue, in MUX_DESEL, op 00 to the same switch with wdata 8'h00.
REQ-025 SHALL, in NEXT, go to MUX_SEL with i+1 if i<NUM_QSFP-1; otherwise it SHALL pulse scan_done and go to WAIT.
REQ-026 SHALL, in WAIT, count POLL_CYCLES and then go to MUX_SEL with i=0 if enable=1, else to IDLE.
REQ-027 SHALL hold cmd_valid and all cmd_* fields stable until the cycle in which cmd_valid&cmd_ready is true.
REQ-028 SHALL have exactly one command outstanding at a time, with the next command issued no earlier than the cycle after rsp_valid.
REQ-029 SHALL, on an rsp_nack or a timeout in CFG, OUT, or RD, set err[i], leave modprsl[i]/intl[i] unchanged, and go to MUX_DESEL.
REQ-030 SHALL, on an rsp_nack or a timeout in MUX_SEL, set err[i] and go to NEXT.
REQ-031 SHALL, on a nack or timeout in MUX_DESEL, set err[i] and proceed to NEXT.
REQ-032 SHALL clear err[i] when cage i completes RD without an error.
REQ-033 SHALL count the timeout from the cmd handshake; rsp_valid arriving exactly at count RSP_TIMEOUT SHALL be accepted, and any later rsp_valid SHALL be ignored.
REQ-034 SHALL set chg[i] when a newly latched modprsl[i] differs from its previous value.
REQ-035 SHALL let set win over chg_clr in the same cycle.
REQ-036 SHALL ignore chg_clr for bits that are not set.
REQ-037 SHALL, when enable is deasserted mid-pass, finish the current cage through MUX_DESEL and then return to IDLE, so no switch channel is left open.
REQ-038 SHALL, with NUM_QSFP not a multiple of QSFP_PER_MUX, only ever address cages 0..NUM_QSFP-1.

Reset
REQ-039 SHALL, on reset, force state IDLE, i=0, cmd_valid=0, cmd_op/dev/reg/wdata=0, modprsl=all-1, intl=all-1, err=0, chg=0, irq=0, scan_done=0, and clear both counters, abandoning any outstanding command.
REQ-040 SHALL treat an rsp_valid arriving after reset, with no command outstanding, as ignored.

Verification
REQ-041 SHALL verify: NUM_QSFP=4, all responses ack, rdata=8'hFE -> 20 commands in order, cage 2 MUX_SEL wdata=8'h01 to dev 8'hE4, scan_done pulses once, modprsl=4'hF, chg=0.
REQ-042 SHALL verify: cage 1 RD rdata changes from 8'hFE to 8'hFA on the second pass -> modprsl[1]=0, chg=4'b0010, irq=1; chg_clr=4'b0010 on the same cycle as a new set -> chg stays 4'b0010.
REQ-043 SHALL verify: nack on cage 3 CFG -> OUT and RD are skipped, MUX_DESEL is issued to 8'hE4 with 8'h00, err=4'b1000; a clean next pass -> err=0.
REQ-044 SHALL verify: no rsp_valid for RSP_TIMEOUT+1 cycles on cage 0 RD -> err[0]=1, MUX_DESEL issued; a late rsp_valid is ignored.
REQ-045 SHALL verify: enable dropped during cage 1 OUT -> RD and MUX_DESEL complete, then IDLE with no further cmd_valid.
REQ-046 SHALL verify: reset asserted while a command is awaiting rsp -> all outputs at reset values next cycle; a scan restarts at cage 0 MUX_SEL.
